// File: rtl/sw_reg_bank.sv
// sw_reg_bank: Wishbone slave exposing C_NUM_REGS 32-bit registers, each either
// processor-writable (byte-lane writes, update strobe) or fabric-driven read-only.
module sw_reg_bank #(
    parameter logic [31:0] C_BASEADDR = 32'h00000000,
    parameter logic [31:0] C_HIGHADDR = 32'h0000FFFF,
    parameter int          C_NUM_REGS = 4,
    parameter logic [15:0] C_RO_MASK  = 16'h0000
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       wb_cyc_i,
    input  logic                       wb_stb_i,
    input  logic                       wb_we_i,
    input  logic [3:0]                 wb_sel_i,
    input  logic [31:0]                wb_adr_i,
    input  logic [31:0]                wb_dat_i,
    output logic [31:0]                wb_dat_o,
    output logic                       wb_ack_o,
    output logic                       wb_err_o,
    input  logic [32*C_NUM_REGS-1:0]   user_data_in,
    output logic [32*C_NUM_REGS-1:0]   user_data_out,
    output logic [C_NUM_REGS-1:0]      user_wr_strobe
);
    logic [31:0] off;
    logic [3:0] idx;
    logic req, bad, ro_hit, err_n, ok, wr;
    logic [C_NUM_REGS-1:0] dec, ro_vec;
    logic [31:0] rd_acc [C_NUM_REGS+1];
    logic unused;

    assign off = wb_adr_i - C_BASEADDR;
    assign idx = off[5:2];
    // Holding off while a response is out gives one response per two cycles on a held strobe.
    assign req = wb_cyc_i && wb_stb_i && wb_adr_i >= C_BASEADDR && wb_adr_i <= C_HIGHADDR
                 && !wb_ack_o && !wb_err_o;
    assign bad = off[31:2] >= 30'(C_NUM_REGS);
    assign ro_hit = |(dec & ro_vec);
    assign err_n = req && (bad || (wb_we_i && ro_hit));
    assign ok = req && !err_n;
    assign wr = ok && wb_we_i;
    assign rd_acc[0] = '0;
    assign unused = ^{off[1:0], user_data_in};

    for (genvar r = 0; r < C_NUM_REGS; r++) begin : g_reg
        assign dec[r] = idx == 4'(r);
        assign ro_vec[r] = C_RO_MASK[r];
        assign rd_acc[r+1] = rd_acc[r] | (dec[r] ? (C_RO_MASK[r] ? user_data_in[32*r +: 32]
                                                                 : user_data_out[32*r +: 32]) : '0);
        if (C_RO_MASK[r]) begin : g_ro
            assign user_data_out[32*r +: 32] = '0;
        end else begin : g_rw
            logic [31:0] q;
            always_ff @(posedge wb_clk_i) begin
                if (!wb_rst_i)
                    q <= '0;
                else if (wr && dec[r])
                    q <= {wb_sel_i[3] ? wb_dat_i[31:24] : q[31:24],
                          wb_sel_i[2] ? wb_dat_i[23:16] : q[23:16],
                          wb_sel_i[1] ? wb_dat_i[15:8]  : q[15:8],
                          wb_sel_i[0] ? wb_dat_i[7:0]   : q[7:0]};
            end
            assign user_data_out[32*r +: 32] = q;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            wb_ack_o       <= 1'b0;
            wb_err_o       <= 1'b0;
            wb_dat_o       <= '0;
            user_wr_strobe <= '0;
        end else begin
            wb_ack_o       <= ok;
            wb_err_o       <= err_n;
            wb_dat_o       <= (ok && !wb_we_i) ? rd_acc[C_NUM_REGS] : '0;
            user_wr_strobe <= (wr && |wb_sel_i) ? dec : '0;
        end
    end
endmodule
